// File: rtl/mem_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter_if
//
// Purpose:
//   Bundles every handshake and data signal around the DataMemory arbiter:
//   the CPU memory-stage request channel, the bus-controller request channel
//   and the single-port DataMemory side.
//
// Signal summary:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata      CPU request and attributes
//   cpu_gnt/cpu_rvalid/cpu_rdata/cpu_err   CPU responses (1-cycle pulses, rdata held)
//   cpu_stall                              CPU pipeline freeze
//   bus_req/bus_we/bus_addr/bus_wdata      bus-controller request and attributes
//   bus_gnt/bus_rvalid/bus_rdata/bus_err   bus-controller responses
//   mem_we/mem_addr/mem_wdata              DataMemory command
//   mem_rdata                              DataMemory read data
//
// Modports:
//   slave  - the arbiter itself (takes requests, drives responses and memory)
//   master - the environment around it (masters plus the memory model)
// -----------------------------------------------------------------------------
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;
    logic              cpu_stall;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, cpu_stall,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, cpu_stall,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Purpose:
//   Shares the single-port DataMemory between the CPU memory stage and the bus
//   controller. Round-robin arbitration with exactly one transaction in flight;
//   reads are sequenced through the memory latency and returned as an rvalid
//   pulse with the data held in a per-master register. Misaligned requests are
//   rejected with an err pulse instead of a grant. cpu_stall freezes the CPU
//   pipeline while its request is pending or its read is outstanding.
//
// Parameters:
//   ADDR_W  address width (byte addresses)
//   DATA_W  data width
//   RD_LAT  cycles from the issue-ending edge to mem_rdata valid, legal 1..4
//
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous reset, active-low
//   io_arb  slave side of mem_access_arbiter_if (CPU, bus and memory signals)
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_arbiter_if.slave   io_arb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic       OWNER_CPU = 1'b0;
    localparam logic       OWNER_BUS = 1'b1;
    localparam logic [2:0] LAT_INIT  = 3'(RD_LAT);

    state_t            r_state;
    state_t            w_nextState;

    logic              r_owner;
    logic              r_rrBus;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_cpuRdata;
    logic [DATA_W-1:0] r_busRdata;

    logic              w_anyReq;
    logic              w_pickBus;
    logic              w_misaligned;
    logic              w_cpuReadBusy;

    logic              w_cpuGnt;
    logic              w_cpuRvalid;
    logic              w_cpuErr;
    logic              w_busGnt;
    logic              w_busRvalid;
    logic              w_busErr;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [DATA_W-1:0] w_memWdata;

    // Arbitration: a lone requester always wins; when both ask, r_rrBus says
    // whether the bus is the one that was not served last.
    assign w_anyReq     = io_arb.cpu_req | io_arb.bus_req;
    assign w_pickBus    = io_arb.bus_req & (~io_arb.cpu_req | r_rrBus);
    assign w_misaligned = (r_addr[1:0] != 2'b00);

    // A CPU-owned aligned read keeps the pipeline frozen from its issue cycle
    // up to, but not including, the response cycle.
    assign w_cpuReadBusy = (r_owner == OWNER_CPU) & ~r_we &
                           (((r_state == ISSUE) & ~w_misaligned) | (r_state == WAIT));

    // State register of the transaction sequencer; reset discards anything
    // in flight so no late rvalid or write can escape.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and response decode. Everything defaults to zero so the
    // memory command and all pulses are quiet unless a state asserts them.
    always_comb begin
        w_nextState = r_state;
        w_cpuGnt    = 1'b0;
        w_cpuRvalid = 1'b0;
        w_cpuErr    = 1'b0;
        w_busGnt    = 1'b0;
        w_busRvalid = 1'b0;
        w_busErr    = 1'b0;
        w_memWe     = 1'b0;
        w_memAddr   = '0;
        w_memWdata  = '0;

        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ISSUE;
                end
            end

            ISSUE: begin
                w_memAddr  = r_addr;
                w_memWdata = r_wdata;
                if (w_misaligned) begin
                    w_cpuErr    = (r_owner == OWNER_CPU);
                    w_busErr    = (r_owner == OWNER_BUS);
                    w_nextState = IDLE;
                end else begin
                    w_cpuGnt    = (r_owner == OWNER_CPU);
                    w_busGnt    = (r_owner == OWNER_BUS);
                    w_memWe     = r_we;
                    w_nextState = r_we ? IDLE : WAIT;
                end
            end

            WAIT: begin
                w_memAddr = r_addr;
                if (r_cnt == 3'd1) begin
                    w_nextState = RESP;
                end
            end

            RESP: begin
                w_cpuRvalid = (r_owner == OWNER_CPU);
                w_busRvalid = (r_owner == OWNER_BUS);
                w_nextState = IDLE;
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Transaction datapath: latch the winner's attributes in IDLE, move the
    // round-robin pointer away from whoever just issued (error or not), run
    // the latency counter and capture read data into the owner's register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWNER_CPU;
            r_rrBus    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_cpuRdata <= '0;
            r_busRdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_owner <= w_pickBus;
                        if (w_pickBus) begin
                            r_we    <= io_arb.bus_we;
                            r_addr  <= io_arb.bus_addr;
                            r_wdata <= io_arb.bus_wdata;
                        end else begin
                            r_we    <= io_arb.cpu_we;
                            r_addr  <= io_arb.cpu_addr;
                            r_wdata <= io_arb.cpu_wdata;
                        end
                    end
                end

                ISSUE: begin
                    r_rrBus <= ~r_owner;
                    if (!w_misaligned && !r_we) begin
                        r_cnt <= LAT_INIT;
                    end
                end

                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        if (r_owner == OWNER_BUS) begin
                            r_busRdata <= io_arb.mem_rdata;
                        end else begin
                            r_cpuRdata <= io_arb.mem_rdata;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // Stall releases in the CPU's write-grant cycle, its error cycle and its
    // read-response cycle; otherwise a pending CPU request holds the pipe.
    assign io_arb.cpu_stall  = (io_arb.cpu_req & ~(w_cpuGnt & io_arb.cpu_we) & ~w_cpuErr)
                               | w_cpuReadBusy;

    assign io_arb.cpu_gnt    = w_cpuGnt;
    assign io_arb.cpu_rvalid = w_cpuRvalid;
    assign io_arb.cpu_err    = w_cpuErr;
    assign io_arb.cpu_rdata  = r_cpuRdata;
    assign io_arb.bus_gnt    = w_busGnt;
    assign io_arb.bus_rvalid = w_busRvalid;
    assign io_arb.bus_err    = w_busErr;
    assign io_arb.bus_rdata  = r_busRdata;
    assign io_arb.mem_we     = w_memWe;
    assign io_arb.mem_addr   = w_memAddr;
    assign io_arb.mem_wdata  = w_memWdata;

endmodule
